// File: rtl/layer_seq_pkg.sv
// Shared types and sizing helpers for the layer sequencer.
package layer_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CLEAR,
        STREAM,
        WAIT,
        DRAIN
    } state_t;

    localparam int CLEAR_CYCLES = 2;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// Activation input stream and result output stream of the layer sequencer.
interface layer_sequencer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int IDX_W      = 4
) ();
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [IDX_W-1:0]      out_index;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_index, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_index, out_valid
    );
endinterface

// File: rtl/act_buffer.sv
// Single-port activation RAM with a registered (1-cycle) read.
module act_buffer
    import layer_seq_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    we_i,
    input  logic [idx_w(DEPTH)-1:0] addr_i,
    input  logic [WIDTH-1:0]        wdata_i,
    output logic [WIDTH-1:0]        rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/layer_sequencer.sv
// Sequences one fully-connected layer: load vector, clear, broadcast, collect, drain.
// States: IDLE cfg/start | LOAD fill buffer | CLEAR clear neurons | STREAM broadcast | WAIT collect | DRAIN emit results
module layer_sequencer
    import layer_seq_pkg::*;
#(
    parameter int NUM_INPUTS  = 256,
    parameter int NUM_NEURONS = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int TIMEOUT     = 1024
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic                              error,
    layer_sequencer_if.slave                  io,
    output logic                              neuron_clear,
    output logic                              neuron_start,
    output logic [DATA_WIDTH-1:0]             neuron_in,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] neuron_out,
    input  logic [NUM_NEURONS-1:0]            neuron_out_valid,
    input  logic                              cfg_valid,
    output logic                              cfg_ready,
    input  logic                              cfg_is_bias,
    input  logic [idx_w(NUM_NEURONS)-1:0]     cfg_neuron,
    input  logic [31:0]                       cfg_data,
    output logic [NUM_NEURONS-1:0]            weight_we,
    output logic [NUM_NEURONS-1:0]            bias_we,
    output logic [31:0]                       cfg_data_out
);
    localparam int IW = idx_w(NUM_NEURONS);
    localparam int AW = idx_w(NUM_INPUTS);
    localparam int LW = cnt_w(NUM_INPUTS);
    localparam int TW = idx_w(TIMEOUT);
    localparam int CW = idx_w(CLEAR_CYCLES);

    state_t                  state_q;
    logic [LW-1:0]           load_cnt_q;
    logic [LW-1:0]           str_cnt_q;
    logic [AW-1:0]           raddr_q;
    logic [CW-1:0]           clr_cnt_q;
    logic [TW-1:0]           wait_cnt_q;
    logic [NUM_NEURONS-1:0]  captured_q;
    logic [DATA_WIDTH-1:0]   result_q [NUM_NEURONS];
    logic                    done_q, error_q, clear_q, nstart_q, out_valid_q;
    logic [DATA_WIDTH-1:0]   neuron_in_q, out_data_q;
    logic [IW-1:0]           out_index_q;
    logic [NUM_NEURONS-1:0]  weight_we_q, bias_we_q;
    logic [31:0]             cfg_data_q;

    logic                    buf_we;
    logic [AW-1:0]           buf_addr;
    logic [DATA_WIDTH-1:0]   buf_rdata;

    // Outside LOAD the RAM port reads one address ahead of the broadcast register.
    assign buf_we   = (state_q == LOAD) && io.in_valid;
    assign buf_addr = (state_q == LOAD) ? load_cnt_q[AW-1:0] : raddr_q;

    act_buffer #(
        .DEPTH (NUM_INPUTS),
        .WIDTH (DATA_WIDTH)
    ) u_act_buffer (
        .clk     (clk),
        .we_i    (buf_we),
        .addr_i  (buf_addr),
        .wdata_i (io.in_data),
        .rdata_o (buf_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            load_cnt_q  <= '0;
            str_cnt_q   <= '0;
            raddr_q     <= '0;
            clr_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            captured_q  <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) result_q[i] <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            clear_q     <= 1'b0;
            nstart_q    <= 1'b0;
            out_valid_q <= 1'b0;
            neuron_in_q <= '0;
            out_data_q  <= '0;
            out_index_q <= '0;
            weight_we_q <= '0;
            bias_we_q   <= '0;
            cfg_data_q  <= '0;
        end else begin
            weight_we_q <= '0;
            bias_we_q   <= '0;
            done_q      <= 1'b0;
            nstart_q    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cfg_valid) begin
                        cfg_data_q <= cfg_data;
                        if ({1'b0, cfg_neuron} < (IW+1)'(NUM_NEURONS)) begin
                            if (cfg_is_bias) bias_we_q   <= NUM_NEURONS'(1) << cfg_neuron;
                            else             weight_we_q <= NUM_NEURONS'(1) << cfg_neuron;
                        end
                    end else if (start) begin
                        state_q    <= LOAD;
                        error_q    <= 1'b0;
                        load_cnt_q <= '0;
                        captured_q <= '0;
                    end
                end
                LOAD: begin
                    if (io.in_valid) begin
                        load_cnt_q <= load_cnt_q + 1'b1;
                        if (load_cnt_q == LW'(NUM_INPUTS - 1)) begin
                            state_q   <= CLEAR;
                            clear_q   <= 1'b1;
                            clr_cnt_q <= '0;
                            raddr_q   <= '0;
                        end
                    end
                end
                CLEAR: begin
                    if (clr_cnt_q == CW'(CLEAR_CYCLES - 1)) begin
                        state_q   <= STREAM;
                        clear_q   <= 1'b0;
                        nstart_q  <= 1'b1;
                        raddr_q   <= raddr_q + 1'b1;
                        str_cnt_q <= '0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                    end
                end
                STREAM: begin
                    neuron_in_q <= buf_rdata;
                    raddr_q     <= raddr_q + 1'b1;
                    str_cnt_q   <= str_cnt_q + 1'b1;
                    if (str_cnt_q == LW'(NUM_INPUTS - 1)) begin
                        state_q    <= WAIT;
                        wait_cnt_q <= TW'(TIMEOUT - 1);
                    end
                end
                WAIT: begin
                    for (int i = 0; i < NUM_NEURONS; i++) begin
                        if (neuron_out_valid[i] && !captured_q[i]) begin
                            result_q[i]   <= neuron_out[i*DATA_WIDTH +: DATA_WIDTH];
                            captured_q[i] <= 1'b1;
                        end
                    end
                    if (&captured_q) begin
                        state_q     <= DRAIN;
                        out_valid_q <= 1'b1;
                        out_index_q <= '0;
                        out_data_q  <= result_q[0];
                    end else if (wait_cnt_q == '0) begin
                        state_q <= IDLE;
                        error_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 1'b1;
                    end
                end
                DRAIN: begin
                    if (io.out_ready) begin
                        if (out_index_q == IW'(NUM_NEURONS - 1)) begin
                            state_q     <= IDLE;
                            out_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            out_index_q <= out_index_q + 1'b1;
                            out_data_q  <= result_q[out_index_q + 1'b1];
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy         = (state_q != IDLE);
    assign cfg_ready    = (state_q == IDLE);
    assign io.in_ready  = (state_q == LOAD);
    assign io.out_valid = out_valid_q;
    assign io.out_data  = out_data_q;
    assign io.out_index = out_index_q;
    assign done         = done_q;
    assign error        = error_q;
    assign neuron_clear = clear_q;
    assign neuron_start = nstart_q;
    assign neuron_in    = neuron_in_q;
    assign weight_we    = weight_we_q;
    assign bias_we      = bias_we_q;
    assign cfg_data_out = cfg_data_q;
endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: config vector table plus randomized and directed layer runs.
module tb_layer_sequencer;
    localparam int NI    = 4;
    localparam int NN    = 3;
    localparam int DW    = 8;
    localparam int TO    = 8;
    localparam int IW    = 2;
    localparam int NEVER = 1000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic busy, done, error;
    logic neuron_clear, neuron_start;
    logic [DW-1:0] neuron_in;
    logic [NN*DW-1:0] n_out = '0;
    logic [NN-1:0] n_valid = '0;
    logic cfg_valid = 1'b0;
    logic cfg_ready;
    logic cfg_is_bias = 1'b0;
    logic [IW-1:0] cfg_neuron = '0;
    logic [31:0] cfg_data = '0;
    logic [NN-1:0] weight_we, bias_we;
    logic [31:0] cfg_data_out;

    layer_sequencer_if #(.DATA_WIDTH(DW), .IDX_W(IW)) io ();

    layer_sequencer #(
        .NUM_INPUTS  (NI),
        .NUM_NEURONS (NN),
        .DATA_WIDTH  (DW),
        .TIMEOUT     (TO)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .io               (io),
        .neuron_clear     (neuron_clear),
        .neuron_start     (neuron_start),
        .neuron_in        (neuron_in),
        .neuron_out       (n_out),
        .neuron_out_valid (n_valid),
        .cfg_valid        (cfg_valid),
        .cfg_ready        (cfg_ready),
        .cfg_is_bias      (cfg_is_bias),
        .cfg_neuron       (cfg_neuron),
        .cfg_data         (cfg_data),
        .weight_we        (weight_we),
        .bias_we          (bias_we),
        .cfg_data_out     (cfg_data_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Scenario description for one layer run; expectations are derived from it.
    logic [DW-1:0] r_vec     [NI];
    logic [DW-1:0] r_val     [NN];
    logic [DW-1:0] r_dup_val [NN];
    int            r_dly     [NN];
    int            r_dup     [NN];
    int            r_rdy_pct;
    int            r_stall;

    typedef struct {
        logic [IW-1:0] nrn;
        logic          bias;
        logic [31:0]   data;
        logic          st;
        logic [NN-1:0] exp_w;
        logic [NN-1:0] exp_b;
    } cfg_vec_t;

    cfg_vec_t cv [7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_in_ready", io.in_ready, 0);
        check("rst_out_valid", io.out_valid, 0);
        check("rst_clear", neuron_clear, 0);
        check("rst_nstart", neuron_start, 0);
        check("rst_we", {weight_we, bias_we}, 0);
        check("rst_neuron_in", neuron_in, 0);
        check("rst_out_data", io.out_data, 0);
        check("rst_out_index", io.out_index, 0);
        check("rst_cfg_data_out", cfg_data_out, 0);
        check("rst_cfg_ready", cfg_ready, 1);
    endtask

    // The earliest pulse of a neuron is the one that must be reported.
    function automatic logic [DW-1:0] first_value(input int i);
        return (r_dup[i] < r_dly[i]) ? r_dup_val[i] : r_val[i];
    endfunction

    task automatic start_and_load(output bit found);
        int clr_seen;
        int gaps;
        found = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("error_cleared", error, 0);
        for (int k = 0; k < NI; k++) begin
            gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) begin
                io.in_valid = 1'b0;
                io.in_data  = DW'($urandom);
                cfg_valid   = 1'($urandom_range(0, 1));
                cfg_neuron  = IW'($urandom);
                start       = 1'($urandom_range(0, 1));
                check("in_ready_load", io.in_ready, 1);
                check("cfg_ready_busy", cfg_ready, 0);
                check("no_cfg_we_busy", {weight_we, bias_we}, 0);
                step();
            end
            io.in_valid = 1'b1;
            io.in_data  = r_vec[k];
            check("in_ready_load", io.in_ready, 1);
            check("no_cfg_we_busy", {weight_we, bias_we}, 0);
            step();
        end
        cfg_valid   = 1'b0;
        start       = 1'b0;
        io.in_valid = 1'b1;
        io.in_data  = DW'($urandom);
        check("in_ready_drop", io.in_ready, 0);
        clr_seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (neuron_start) begin
                found = 1'b1;
                break;
            end
            if (neuron_clear) clr_seen++;
            step();
        end
        io.in_valid = 1'b0;
        check("neuron_start_seen", 32'(found), 1);
        check("clear_cycles", clr_seen, 2);
    endtask

    task automatic stream_check();
        for (int k = 0; k < NI; k++) begin
            step();
            check("neuron_in", neuron_in, r_vec[k]);
            check("nstart_single", neuron_start, 0);
        end
    endtask

    task automatic wait_phase(input bit exp_to);
        int last;
        last = 0;
        for (int i = 0; i < NN; i++) if (r_dly[i] != NEVER && r_dly[i] > last) last = r_dly[i];
        if (exp_to) last = TO - 1;
        for (int j = 0; j <= last; j++) begin
            for (int i = 0; i < NN; i++) begin
                if (r_dly[i] == j) begin
                    n_valid[i] = 1'b1;
                    n_out[i*DW +: DW] = r_val[i];
                end else if (r_dup[i] == j) begin
                    n_valid[i] = 1'b1;
                    n_out[i*DW +: DW] = r_dup_val[i];
                end else begin
                    n_valid[i] = 1'b0;
                    n_out[i*DW +: DW] = DW'($urandom);
                end
            end
            if (exp_to) begin
                check("no_early_error", error, 0);
                check("busy_in_wait", busy, 1);
            end
            step();
        end
        n_valid = '0;
    endtask

    task automatic drain();
        int hs;
        int stall_left;
        bit rdy, prev_stall;
        logic [DW-1:0] prev_d;
        logic [IW-1:0] prev_i;
        hs = 0;
        stall_left = r_stall;
        prev_stall = 1'b0;
        prev_d = '0;
        prev_i = '0;
        for (int c = 0; c < 300 && hs < NN; c++) begin
            rdy = ($urandom_range(0, 99) < r_rdy_pct);
            if (hs == 1 && stall_left > 0 && io.out_valid) begin
                rdy = 1'b0;
                stall_left--;
            end
            check("done_early", done, 0);
            if (prev_stall) begin
                check("hold_valid", io.out_valid, 1);
                check("hold_data", io.out_data, prev_d);
                check("hold_index", io.out_index, prev_i);
            end
            prev_stall = 1'b0;
            if (io.out_valid) begin
                if (rdy) begin
                    check("out_index", io.out_index, hs);
                    check("out_data", io.out_data, first_value(hs));
                    hs++;
                end else begin
                    prev_stall = 1'b1;
                    prev_d = io.out_data;
                    prev_i = io.out_index;
                end
            end
            io.out_ready = rdy;
            step();
        end
        io.out_ready = 1'b0;
        check("drain_count", hs, NN);
        check("done_pulse", done, 1);
        check("idle_after_done", busy, 0);
        check("out_valid_after_done", io.out_valid, 0);
        step();
        check("done_one_cycle", done, 0);
    endtask

    task automatic do_run(input bit exp_to);
        bit found;
        start_and_load(found);
        if (found) begin
            stream_check();
            wait_phase(exp_to);
            if (exp_to) begin
                check("timeout_error", error, 1);
                check("timeout_idle", busy, 0);
                check("timeout_no_done", done, 0);
                check("timeout_no_valid", io.out_valid, 0);
                step();
                check("timeout_no_done_later", done, 0);
                check("error_sticky", error, 1);
            end else begin
                drain();
            end
        end
    endtask

    task automatic rand_setup(input bit make_to);
        int maxd;
        int victim;
        for (int k = 0; k < NI; k++) r_vec[k] = DW'($urandom);
        maxd = 0;
        for (int i = 0; i < NN; i++) begin
            r_val[i] = DW'($urandom);
            r_dup_val[i] = DW'($urandom);
            r_dly[i] = $urandom_range(0, TO - 2);
            if (r_dly[i] > maxd) maxd = r_dly[i];
        end
        for (int i = 0; i < NN; i++) begin
            if (r_dly[i] < maxd && $urandom_range(0, 1) == 1) r_dup[i] = $urandom_range(r_dly[i] + 1, maxd);
            else r_dup[i] = NEVER;
        end
        if (make_to) begin
            victim = $urandom_range(0, NN - 1);
            r_dly[victim] = NEVER;
            r_dup[victim] = NEVER;
        end
        r_rdy_pct = $urandom_range(30, 100);
        r_stall = 0;
    endtask

    initial begin
        bit found;
        io.in_valid  = 1'b0;
        io.in_data   = '0;
        io.out_ready = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        check_reset_outputs();

        cv[0] = '{2'd1, 1'b1, 32'h0000_0005, 1'b0, 3'b000, 3'b010};
        cv[1] = '{2'd0, 1'b0, 32'hA5A5_1234, 1'b0, 3'b001, 3'b000};
        cv[2] = '{2'd2, 1'b0, 32'h0BAD_F00D, 1'b0, 3'b100, 3'b000};
        cv[3] = '{2'd2, 1'b1, 32'h1357_9BDF, 1'b0, 3'b000, 3'b100};
        cv[4] = '{2'd0, 1'b1, 32'hFFFF_0001, 1'b0, 3'b000, 3'b001};
        cv[5] = '{2'd3, 1'b0, 32'h7777_7777, 1'b0, 3'b000, 3'b000};
        cv[6] = '{2'd1, 1'b0, 32'h2468_ACE0, 1'b1, 3'b010, 3'b000};
        for (int v = 0; v < 7; v++) begin
            check("cfg_ready_idle", cfg_ready, 1);
            cfg_valid   = 1'b1;
            cfg_neuron  = cv[v].nrn;
            cfg_is_bias = cv[v].bias;
            cfg_data    = cv[v].data;
            start       = cv[v].st;
            step();
            cfg_valid = 1'b0;
            start     = 1'b0;
            check("cfg_weight_we", weight_we, cv[v].exp_w);
            check("cfg_bias_we", bias_we, cv[v].exp_b);
            check("cfg_start_ignored", busy, 0);
            if ((cv[v].exp_w | cv[v].exp_b) != '0) check("cfg_data_out", cfg_data_out, cv[v].data);
            step();
            check("cfg_we_one_cycle", {weight_we, bias_we}, 0);
        end

        // Basic run: inputs 1..4, each neuron reports a fixed value.
        for (int k = 0; k < NI; k++) r_vec[k] = DW'(k + 1);
        r_val[0] = 8'h11; r_val[1] = 8'h22; r_val[2] = 8'h33;
        for (int i = 0; i < NN; i++) begin
            r_dly[i] = i;
            r_dup[i] = NEVER;
            r_dup_val[i] = '0;
        end
        r_rdy_pct = 100;
        r_stall = 0;
        do_run(1'b0);

        // Consumer stalls for five cycles in the middle of the drain.
        rand_setup(1'b0);
        r_rdy_pct = 100;
        r_stall = 5;
        do_run(1'b0);

        // Neuron 1 reports first and then again with a different value.
        rand_setup(1'b0);
        r_dly[0] = 3; r_dly[1] = 0; r_dly[2] = 1;
        r_dup[0] = NEVER; r_dup[1] = 2; r_dup[2] = NEVER;
        r_val[1] = 8'h22; r_dup_val[1] = 8'h99;
        do_run(1'b0);

        // Neuron 0 never reports.
        rand_setup(1'b0);
        r_dly[0] = NEVER;
        r_dup[0] = NEVER;
        do_run(1'b1);

        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_clears_error", error, 0);

        // Abort in the middle of the broadcast, then a clean run.
        rand_setup(1'b0);
        start_and_load(found);
        step();
        step();
        check("busy_in_stream", busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_outputs();
        rand_setup(1'b0);
        do_run(1'b0);

        for (int r = 0; r < 20; r++) begin
            rand_setup(r % 7 == 3);
            do_run(r % 7 == 3);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_err);
        $fatal(1, "time limit");
    end
endmodule
